if_prefetch_buffer: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the riscv_stub IF stage, between instruction memory and the core.
- Issues sequential word fetches ahead of the core and holds returned instructions, tagged with their PC, in a small FIFO.
- Handles control-flow redirects (branch/jump/exception) by flushing buffered instructions and discarding in-flight stale responses.

---
 rtl/if_prefetch_buffer.sv | 119 +++++++++++
 tb/tb_if_prefetch_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches ahead of the core,
// keeps returned instructions tagged with their PC in a small FIFO, and handles
// redirects by flushing the FIFO and discarding responses that are still in flight.
module if_prefetch_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);      // FIFO pointer width
    localparam int CW = $clog2(DEPTH + 1);  // counters that reach DEPTH
    localparam int OW = CW + 1;             // sum of two such counters

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] rsp_pc;
    logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         discard;

    logic [OW-1:0]         occupancy;
    logic                  issue;
    logic                  rsp_take;
    logic                  rsp_drop;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         in_flight_after_rsp;
    logic [DATA_WIDTH-1:0] redirect_base;

    // Credit: buffered plus outstanding may never exceed the FIFO size, so every
    // response always has a slot waiting for it.
    assign occupancy     = OW'(count) + OW'(in_flight);
    assign mem_req_valid = !redirect_valid && (occupancy < OW'(DEPTH));
    assign mem_addr      = fetch_pc;
    assign issue         = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take = mem_rsp_valid && (in_flight != '0);
    assign rsp_drop = rsp_take && (discard != '0);
    assign push     = rsp_take && (discard == '0) && !redirect_valid;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    // Outputs are forced to zero while empty so nothing flushed can leak out.
    assign instr_data = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc   = instr_valid ? pc_mem[rd_ptr]   : '0;

    assign in_flight_after_rsp = in_flight - CW'(rsp_take);
    assign redirect_base       = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    // Control state: fetch/response PCs, FIFO pointers, credit and discard counters.
    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
            discard   <= '0;
        end else if (redirect_valid) begin
            // Flush, restart both PCs, and mark every outstanding request stale.
            fetch_pc  <= redirect_base;
            rsp_pc    <= redirect_base;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= in_flight_after_rsp;
            discard   <= in_flight_after_rsp;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            end
            in_flight <= in_flight_after_rsp + CW'(issue);
            if (rsp_drop) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + DATA_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; instr_valid gates the read path, so
    // stale contents are never observable and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer: a queue-based reference model and a
// latency-randomised in-order memory, directed scenarios, then random traffic.
module tb_if_prefetch_buffer;

    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [DW-1:0] mem_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [DW-1:0] instr_pc;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;

    if_prefetch_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents as a queue, outstanding requests as a queue
    // of stale flags (oldest first), plus the two PCs.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;
    entry_t      m_fifo[$];
    bit          m_stale[$];
    logic [31:0] m_fetch;
    logic [31:0] m_rsp;

    // Memory: in-order responses, at most one per cycle, latency lat_lo..lat_hi.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t mq[$];
    int    cyc;
    int    last_due;
    int    lat_lo = 1;
    int    lat_hi = 1;
    bit    spurious_en = 1'b0;

    // Values sampled in the most recent step.
    logic        s_req;
    logic        s_iv;
    logic [31:0] s_addr;
    logic [31:0] s_ipc;
    logic [31:0] s_idata;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_stale.delete();
        m_fetch  = RESET_PC;
        m_rsp    = RESET_PC;
        mq.delete();
        last_due = -1;
        cyc      = 0;
    endtask

    // Holds reset for two edges, checks the reset state, releases at edge+1.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        model_reset();
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs at edge+1, compare at edge+4, advance model.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit ird, input bit mrdy);
        bit          rsp_real;
        bit          exp_req;
        bit          rsp_eff;
        bit          st;
        bit          full_before;
        entry_t      e;
        int          d;
        logic [31:0] aligned;

        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = ird;
        mem_req_ready  = mrdy;
        rsp_real = (mq.size() > 0) && (mq[0].due <= cyc);
        if (rsp_real) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(mq[0].addr);
        end else if (spurious_en && mq.size() == 0 && $urandom_range(0, 49) == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom();
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom();
        end
        #3;
        s_req   = mem_req_valid;
        s_addr  = mem_addr;
        s_iv    = instr_valid;
        s_ipc   = instr_pc;
        s_idata = instr_data;

        exp_req = !redir && (m_fifo.size() + m_stale.size() < DEPTH);
        check("mem_req_valid", s_req, exp_req);
        check("mem_addr", s_addr, m_fetch);
        check("instr_valid", s_iv, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check("instr_pc", s_ipc, m_fifo[0].pc);
            check("instr_data", s_idata, m_fifo[0].data);
        end

        rsp_eff = mem_rsp_valid && (m_stale.size() > 0);
        st = 1'b1;
        if (rsp_eff) st = m_stale.pop_front();
        if (redir) begin
            aligned = rpc & ~32'h3;
            m_fifo.delete();
            foreach (m_stale[i]) m_stale[i] = 1'b1;
            m_fetch = aligned;
            m_rsp   = aligned;
        end else begin
            full_before = (m_fifo.size() == DEPTH);
            if (m_fifo.size() != 0 && ird) void'(m_fifo.pop_front());
            if (rsp_eff && !st) begin
                check("push_while_full", full_before, 1'b0);
                e.pc   = m_rsp;
                e.data = mem_rsp_data;
                m_fifo.push_back(e);
                m_rsp += 4;
            end
            if (exp_req && mrdy) begin
                m_stale.push_back(1'b0);
                m_fetch += 4;
            end
        end

        if (rsp_real) void'(mq.pop_front());
        if (s_req && mrdy) begin
            d = cyc + $urandom_range(lat_lo, lat_hi);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: s_addr, due: d});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  n_iss;
        bit  found;

        // Streaming: memory always ready, 1-cycle latency, core always ready.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (i < 3) check("t1_req_addr", s_addr, 32'(4 * i));
            if (i < 2) check("t1_startup_empty", s_iv, 1'b0);
            if (i >= 2 && i < 6) begin
                check("t1_valid", s_iv, 1'b1);
                check("t1_pc", s_ipc, 32'(4 * (i - 2)));
                check("t1_data", s_idata, mem_word(32'(4 * (i - 2))));
            end
        end

        // Core stalled: exactly DEPTH requests, then one pop frees one credit.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (i < 4) begin
                check("t2_req", s_req, 1'b1);
                check("t2_addr", s_addr, 32'(4 * i));
            end else begin
                check("t2_req_stop", s_req, 1'b0);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t2_pop_pc", s_ipc, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_refill_req", s_req, 1'b1);
        check("t2_refill_addr", s_addr, 32'h10);
        check("t2_head_pc", s_ipc, 32'h4);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_one_only", s_req, 1'b0);

        // 3-cycle memory, two outstanding, redirect to unaligned 0x103.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h103, 1'b1, 1'b1);
        check("t3_no_req_on_redirect", s_req, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t3_req", s_req, 1'b1);
        check("t3_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_iv) begin
                found = 1'b1;
                check("t3_first_pc", s_ipc, 32'h100);
            end
        end
        if (!found) check("t3_timeout", 1'b0, 1'b1);

        // Redirect coinciding with a response and a pop, FIFO holding 0x8 and 0xC.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t4_pre_addr", s_addr, 32'h10);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        check("t4_head_before", s_ipc, 32'h8);
        check("t4_rsp_same_cycle", mem_rsp_valid, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t4_flushed", s_iv, 1'b0);
        check("t4_resume_req", s_req, 1'b1);
        check("t4_resume_addr", s_addr, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_iv) begin
                found = 1'b1;
                check("t4_first_pc", s_ipc, 32'h200);
            end
        end
        if (!found) check("t4_timeout", 1'b0, 1'b1);

        // Redirect to the top of the address space: fetch wraps to zero.
        do_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t5_addr_wrap", s_addr, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t5_pc_top", s_ipc, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t5_pc_wrap", s_ipc, 32'h0);

        // Reset mid-stream with three buffered and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check("t6_pre_valid", instr_valid, 1'b1);
        check("t6_pre_addr", mem_addr, 32'h10);
        #1 reset = 1'b1;
        #1;
        check("t6_async_valid", instr_valid, 1'b0);
        check("t6_async_addr", mem_addr, RESET_PC);
        do_reset();
        n_iss = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (i == 0) check("t6_restart_addr", s_addr, RESET_PC);
            if (s_req) n_iss++;
        end
        check("t6_credit_after_reset", n_iss, DEPTH);

        // Random traffic against the model.
        do_reset();
        lat_lo = 1; lat_hi = 4;
        spurious_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            bit          redir;
            rpc   = $urandom();
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            redir = ($urandom_range(0, 99) < 4);
            step(redir, rpc, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
